gold_seq_gen: RTL

- Generates the 3GPP 36.211 §7.2 length-31 Gold sequence c(n) used to descramble PBCH bits in the MIB decoding chain.
- Built from two 31-bit Fibonacci LFSRs: x1 with fixed init, x2 seeded with c_init.
- Discards the first NC outputs internally, then streams SEQ_LEN bits to the downstream descrambler over a valid/ready handshake.
- Raises a done pulse when the sequence completes; both LFSRs hold while idle to save power.

---
 rtl/gold_seq_gen_pkg.sv | 27 ++
 rtl/gold_lfsr31.sv | 36 +++
 rtl/gold_seq_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/gold_seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gold_seq_gen_pkg
// Description : Shared constants, tap masks and state encoding for the
//               length-31 Gold sequence generator.
// Revision    : 1.0 - initial release
// ============================================================================
package gold_seq_gen_pkg;

  localparam int NC_DEFAULT      = 1600;
  localparam int SEQ_LEN_DEFAULT = 1920;
  localparam int CNT_W_DEFAULT   = 11;
  localparam int CINIT_W_DEFAULT = 31;

  localparam logic [30:0] X1_INIT = 31'h1;
  localparam logic [30:0] X1_TAPS = 31'h9;   // x^31 + x^3 + 1
  localparam logic [30:0] X2_TAPS = 31'hF;   // x^31 + x^3 + x^2 + x + 1

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gold_lfsr31.sv
`default_nettype none
// ============================================================================
// Module      : gold_lfsr31
// Description : 31-bit Fibonacci LFSR, right shift with feedback into bit 30.
// Revision    : 1.0 - initial release
// ============================================================================
module gold_lfsr31 #(
  parameter logic [30:0] TAPS = 31'h9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [30:0] i_load_val,
  input  logic        i_shift,
  output logic        o_bit
);

  logic [30:0] r_sr;
  logic        w_fb;

  assign w_fb = ^(r_sr & TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_load_val;
    end else if (i_shift) begin
      r_sr <= {w_fb, r_sr[30:1]};
    end
  end

  assign o_bit = r_sr[0];

endmodule
`default_nettype wire

// File: rtl/gold_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : gold_seq_gen
// Description : PBCH Gold sequence c(n) generator: NC-shift warm-up, then
//               SEQ_LEN bits streamed over valid/ready, then a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gold_seq_gen
  import gold_seq_gen_pkg::*;
#(
  parameter int NC      = NC_DEFAULT,
  parameter int SEQ_LEN = SEQ_LEN_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int CINIT_W = CINIT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CINIT_W-1:0] cinit_i,
  input  logic               start_i,
  input  logic               seq_ready_i,
  output logic               seq_o,
  output logic               seq_valid_o,
  output logic               seq_last_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [CNT_W-1:0] NC_LAST  = CNT_W'(NC - 1);
  localparam logic [CNT_W-1:0] SEQ_LAST = CNT_W'(SEQ_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_shift;
  logic             w_xfer;
  logic             w_x1_bit;
  logic             w_x2_bit;

  assign w_load  = (r_state == IDLE) && start_i;
  assign w_xfer  = (r_state == STREAM) && seq_ready_i;
  assign w_shift = (r_state == WARMUP) || w_xfer;

  gold_lfsr31 #(.TAPS(X1_TAPS)) u_x1 (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (X1_INIT),
    .i_shift    (w_shift),
    .o_bit      (w_x1_bit)
  );

  gold_lfsr31 #(.TAPS(X2_TAPS)) u_x2 (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (31'(cinit_i)),
    .i_shift    (w_shift),
    .o_bit      (w_x2_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt   <= '0;
            r_state <= (NC == 0) ? STREAM : WARMUP;
          end
        end
        WARMUP: begin
          if (r_cnt == NC_LAST) begin
            r_cnt   <= '0;
            r_state <= STREAM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (seq_ready_i) begin
            if (r_cnt == SEQ_LAST) begin
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state register so they are glitch-free.
  assign seq_valid_o = (r_state == STREAM);
  assign seq_last_o  = (r_state == STREAM) && (r_cnt == SEQ_LAST);
  assign busy_o      = (r_state == WARMUP) || (r_state == STREAM);
  assign done_o      = (r_state == DONE);
  assign seq_o       = w_x1_bit ^ w_x2_bit;

endmodule
`default_nettype wire
